// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bundle of the branch predictor.
// The pipeline (master) drives the fetch PC and resolved-branch results;
// the predictor (slave) returns the prediction, the recovery request and statistics.
interface branch_predictor_if #(
    parameter int STAT_WIDTH = 32
);
    // Fetch-side lookup
    logic [31:0]           fetchPc;
    logic                  predTaken;
    logic [31:0]           predNextPc;

    // Execute-side resolution
    logic                  exValid;
    logic                  exIsBranch;
    logic [31:0]           exPc;
    logic                  exIsTaken;
    logic [31:0]           exIrregPc;
    logic [31:0]           exPredNextPc;

    // Recovery request back to fetch
    logic                  mispredict;
    logic [31:0]           recoverPc;

    // Statistics
    logic [STAT_WIDTH-1:0] branchCount;
    logic [STAT_WIDTH-1:0] mispredictCount;

    modport master (
        output fetchPc,
        output exValid,
        output exIsBranch,
        output exPc,
        output exIsTaken,
        output exIrregPc,
        output exPredNextPc,
        input  predTaken,
        input  predNextPc,
        input  mispredict,
        input  recoverPc,
        input  branchCount,
        input  mispredictCount
    );

    modport slave (
        input  fetchPc,
        input  exValid,
        input  exIsBranch,
        input  exPc,
        input  exIsTaken,
        input  exIrregPc,
        input  exPredNextPc,
        output predTaken,
        output predNextPc,
        output mispredict,
        output recoverPc,
        output branchCount,
        output mispredictCount
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters.
// Combinational next-PC prediction for fetch, training from execute results,
// a registered one-cycle mispredict/recoverPc pulse and saturating statistics.
// The table is held in flops so the asynchronous reset clears it immediately.
module branch_predictor #(
    parameter int ENTRY_NUM  = 64,
    parameter int STAT_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    branch_predictor_if.slave bus
);
    localparam int INDEX_W = $clog2(ENTRY_NUM);
    localparam int TAG_W   = 32 - INDEX_W - 2;

    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_ALLOC = 2'b10;

    // Increment/decrement a 2-bit counter without wrapping.
    function automatic logic [1:0] sat_inc(input logic [1:0] value);
        return (value == 2'b11) ? 2'b11 : value + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] value);
        return (value == 2'b00) ? 2'b00 : value - 2'b01;
    endfunction

    // Flattened view of every entry, gathered from the per-entry storage below.
    logic [ENTRY_NUM-1:0] valid_all;
    logic [TAG_W-1:0]     tag_all    [ENTRY_NUM];
    logic [31:0]          target_all [ENTRY_NUM];
    logic [1:0]           ctr_all    [ENTRY_NUM];

    // Lookup side
    logic [INDEX_W-1:0] fetch_idx;
    logic [TAG_W-1:0]   fetch_tag;
    logic               fetch_hit;
    logic               fetch_taken;

    // Update side
    logic [INDEX_W-1:0] ex_idx;
    logic [TAG_W-1:0]   ex_tag;
    logic               ex_hit;
    logic               upd;
    logic               mis;

    // Registered outputs
    logic                  mispredict_reg;
    logic [31:0]           recover_pc_reg;
    logic [STAT_WIDTH-1:0] branch_count_reg;
    logic [STAT_WIDTH-1:0] mispredict_count_reg;

    // Byte-offset bits of the PCs never affect indexing or tags.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.fetchPc[1:0], bus.exPc[1:0]};

    assign fetch_idx = bus.fetchPc[INDEX_W+1:2];
    assign fetch_tag = bus.fetchPc[31:INDEX_W+2];
    assign ex_idx    = bus.exPc[INDEX_W+1:2];
    assign ex_tag    = bus.exPc[31:INDEX_W+2];

    assign upd = bus.exValid && bus.exIsBranch;
    assign mis = upd && (bus.exIrregPc != bus.exPredNextPc);

    // Lookup reads the current table contents; an update in the same cycle
    // only becomes visible after the clock edge (no bypass).
    always_comb begin
        fetch_hit   = valid_all[fetch_idx] && (tag_all[fetch_idx] == fetch_tag);
        fetch_taken = fetch_hit && ctr_all[fetch_idx][1];
    end

    // Hit check for the resolving branch against its own entry.
    always_comb begin
        ex_hit = valid_all[ex_idx] && (tag_all[ex_idx] == ex_tag);
    end

    assign bus.predTaken  = fetch_taken;
    assign bus.predNextPc = fetch_taken ? target_all[fetch_idx] : bus.fetchPc + 32'd4;

    generate
        for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_entry
            logic             valid_reg;
            logic [TAG_W-1:0] tag_reg;
            logic [31:0]      target_reg;
            logic [1:0]       ctr_reg;
            logic             sel;

            assign sel = upd && (ex_idx == INDEX_W'(gi));

            // Train this entry when the resolving branch maps onto it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    ctr_reg    <= CTR_RESET;
                end else if (sel) begin
                    if (bus.exIsTaken) begin
                        if (ex_hit) begin
                            ctr_reg    <= sat_inc(ctr_reg);
                            target_reg <= bus.exIrregPc;
                        end else begin
                            // Taken branch not in the table: claim the slot,
                            // evicting whatever aliased there.
                            valid_reg  <= 1'b1;
                            tag_reg    <= ex_tag;
                            target_reg <= bus.exIrregPc;
                            ctr_reg    <= CTR_ALLOC;
                        end
                    end else if (ex_hit) begin
                        ctr_reg <= sat_dec(ctr_reg);
                    end
                    // Not-taken miss leaves the table alone.
                end
            end

            assign valid_all[gi]  = valid_reg;
            assign tag_all[gi]    = tag_reg;
            assign target_all[gi] = target_reg;
            assign ctr_all[gi]    = ctr_reg;
        end
    endgenerate

    // Recovery pulse, held recovery PC and saturating statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_reg       <= 1'b0;
            recover_pc_reg       <= '0;
            branch_count_reg     <= '0;
            mispredict_count_reg <= '0;
        end else begin
            mispredict_reg <= mis;
            if (mis) begin
                recover_pc_reg <= bus.exIrregPc;
            end
            if (upd && (branch_count_reg != '1)) begin
                branch_count_reg <= branch_count_reg + STAT_WIDTH'(1);
            end
            if (mis && (mispredict_count_reg != '1)) begin
                mispredict_count_reg <= mispredict_count_reg + STAT_WIDTH'(1);
            end
        end
    end

    assign bus.mispredict      = mispredict_reg;
    assign bus.recoverPc       = recover_pc_reg;
    assign bus.branchCount     = branch_count_reg;
    assign bus.mispredictCount = mispredict_count_reg;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: each vector pushes its hand-computed
// expectation into a queue and a separate monitor compares at the falling edge.
module tb_branch_predictor;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    branch_predictor_if #(.STAT_WIDTH(SW)) bus ();

    branch_predictor #(
        .ENTRY_NUM (64),
        .STAT_WIDTH(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        int          id;
        logic        pt;
        logic [31:0] pnpc;
        logic        mis;
        logic [31:0] rpc;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_id   = 0;

    task automatic check_val(input string name, input int id,
                             input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d actual=0x%08h required=0x%08h", name, id, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("vec %0d fetchPc=0x%08h predTaken=%0b predNextPc=0x%08h mispredict=%0b recoverPc=0x%08h branchCount=%0d mispredictCount=%0d",
                         e.id, bus.fetchPc, bus.predTaken, bus.predNextPc, bus.mispredict,
                         bus.recoverPc, bus.branchCount, bus.mispredictCount);
                check_val("predTaken", e.id, {31'd0, bus.predTaken}, {31'd0, e.pt});
                check_val("predNextPc", e.id, bus.predNextPc, e.pnpc);
                check_val("mispredict", e.id, {31'd0, bus.mispredict}, {31'd0, e.mis});
                check_val("recoverPc", e.id, bus.recoverPc, e.rpc);
                check_val("branchCount", e.id, {28'd0, bus.branchCount}, e.bc);
                check_val("mispredictCount", e.id, {28'd0, bus.mispredictCount}, e.mc);
            end
        end
    end

    // Drive one cycle of inputs (away from the edge) and queue what must be seen.
    task automatic step(input logic [31:0] fpc, input logic ev, input logic eb,
                        input logic [31:0] epc, input logic et,
                        input logic [31:0] eirr, input logic [31:0] epred,
                        input logic xpt, input logic [31:0] xpnpc,
                        input logic xmis, input logic [31:0] xrpc,
                        input int xbc, input int xmc);
        exp_t e;
        @(posedge clk);
        #1;
        bus.fetchPc      = fpc;
        bus.exValid      = ev;
        bus.exIsBranch   = eb;
        bus.exPc         = epc;
        bus.exIsTaken    = et;
        bus.exIrregPc    = eirr;
        bus.exPredNextPc = epred;
        vec_id++;
        e.id   = vec_id;
        e.pt   = xpt;
        e.pnpc = xpnpc;
        e.mis  = xmis;
        e.rpc  = xrpc;
        e.bc   = 32'(xbc);
        e.mc   = 32'(xmc);
        exp_q.push_back(e);
    endtask

    initial begin
        int waited;
        rst              = 1'b1;
        bus.fetchPc      = '0;
        bus.exValid      = 1'b0;
        bus.exIsBranch   = 1'b0;
        bus.exPc         = '0;
        bus.exIsTaken    = 1'b0;
        bus.exIrregPc    = '0;
        bus.exPredNextPc = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        //     fetchPc       ev  eb  exPc          tk  irr           pred          pt  predNextPc    mis rpc          bc  mc
        // Reset state
        step(32'h0000_0100, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0000_0104, 0, 32'h0,      0,  0);
        // Allocate 0x100 -> 0x200 while fetching it: no bypass this cycle
        step(32'h0000_0100, 1, 1, 32'h100,      1, 32'h200,      32'h104,      0, 32'h0000_0104, 0, 32'h0,      0,  0);
        // Entry visible, mispredict pulse from the allocation
        step(32'h0000_0100, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0000_0200, 1, 32'h200,    1,  1);
        // Not taken on ctr=10 -> ctr=01
        step(32'h0000_0100, 1, 1, 32'h100,      0, 32'h104,      32'h200,      1, 32'h0000_0200, 0, 32'h200,    1,  1);
        // Now predicted not taken; taken resolve -> ctr=10 (back-to-back mispredict)
        step(32'h0000_0100, 1, 1, 32'h100,      1, 32'h200,      32'h104,      0, 32'h0000_0104, 1, 32'h104,    2,  2);
        // Correct taken resolve -> ctr=11, no mispredict
        step(32'h0000_0100, 1, 1, 32'h100,      1, 32'h200,      32'h200,      1, 32'h0000_0200, 1, 32'h200,    3,  3);
        // Not taken on ctr=11 -> ctr=10
        step(32'h0000_0100, 1, 1, 32'h100,      0, 32'h104,      32'h200,      1, 32'h0000_0200, 0, 32'h200,    4,  3);
        // Still predicted taken (hysteresis)
        step(32'h0000_0100, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0000_0200, 1, 32'h104,    5,  4);
        // Non-branch with exValid: no effect
        step(32'h0000_0100, 1, 0, 32'h100,      0, 32'h999,      32'h0,        1, 32'h0000_0200, 0, 32'h104,    5,  4);
        // exValid=0 branch: no effect; 0x200 aliases idx 0 but misses on tag
        step(32'h0000_0200, 0, 1, 32'h100,      0, 32'h104,      32'h200,      0, 32'h0000_0204, 0, 32'h104,    5,  4);
        // 0x100 unchanged; allocate 0x200 -> 0x300 over it
        step(32'h0000_0100, 1, 1, 32'h200,      1, 32'h300,      32'h204,      1, 32'h0000_0200, 0, 32'h104,    5,  4);
        // 0x100 now misses on tag
        step(32'h0000_0100, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0000_0104, 1, 32'h300,    6,  5);
        // 0x200 predicts its target
        step(32'h0000_0200, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0000_0300, 0, 32'h300,    6,  5);
        // PC wrap on miss; correctly predicted not-taken miss counts as a branch only
        step(32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,       32'h0,        0, 32'h0000_0000, 0, 32'h300,    6,  5);
        // Mispredicted not-taken miss: pulse but no allocation
        step(32'hFFFF_FFFC, 1, 1, 32'h340,      0, 32'h344,      32'h500,      0, 32'h0000_0000, 0, 32'h300,    7,  5);
        step(32'h0000_0340, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0000_0344, 1, 32'h344,    8,  6);

        // Stream of mispredicts at 0x600 -> 0x700; both counters saturate at 15
        for (int k = 0; k < 12; k++) begin
            step(32'h0000_0010, 1, 1, 32'h600, 1, 32'h700, 32'h604,
                 0, 32'h0000_0014, (k > 0), (k > 0) ? 32'h700 : 32'h344,
                 (8 + k > 15) ? 15 : 8 + k, (6 + k > 15) ? 15 : 6 + k);
        end

        // Reset asserted mid-cycle right after a mispredict edge: all clears at once
        step(32'h0000_0600, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0000_0604, 0, 32'h0, 0, 0);
        rst = 1'b1;
        step(32'h0000_0600, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0000_0604, 0, 32'h0, 0, 0);
        rst = 1'b0;
        step(32'h0000_0600, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0000_0604, 0, 32'h0, 0, 0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart of the execute-stage branch resolver.
- Predicts the next fetch PC from a direct-mapped BTB with 2-bit saturating counters.
- Trains the table from resolved branch outcomes returned by execute.
- Detects mispredictions and issues a registered one-cycle recovery request (mispredict + recoverPc) back to fetch. Keeps saturating branch/mispredict statistics.

Parameters:
ENTRY_NUM, 64, number of BTB entries; power of two, >= 2; INDEX_W = log2(ENTRY_NUM)
STAT_WIDTH, 32, width of statistics counters

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
fetchPc  input  32  PC currently being fetched
predTaken  output  1  combinational: predicted taken for fetchPc
predNextPc  output  32  combinational: predicted next fetch PC
exValid  input  1  execute-stage result valid this cycle
exIsBranch  input  1  resolved instruction is a branch/jump
exPc  input  32  PC of resolved instruction
exIsTaken  input  1  resolved taken
exIrregPc  input  32  resolved next PC (target if taken, exPc+4 if not)
exPredNextPc  input  32  predNextPc carried down the pipe for this instruction
mispredict  output  1  registered one-cycle recovery pulse
recoverPc  output  32  registered correct next PC, valid when mispredict=1
branchCount  output  STAT_WIDTH  resolved branches, saturating
mispredictCount  output  STAT_WIDTH  mispredictions, saturating

Behaviour:
- Entry fields: valid(1), tag(32-INDEX_W-2), target(32), ctr(2). idx = pc[INDEX_W+1:2], tag = pc[31:INDEX_W+2]. pc[1:0] ignored.
- Reset (async, any time including mid-update): all valid=0, all ctr=2'b01, mispredict=0, recoverPc=0, both stat counters=0. Table may be implemented as registers so reset clears it immediately.
- Lookup (combinational, same cycle):
  - hit = valid[idx] && tag match.
  - predTaken = hit && ctr[1].
  - predNextPc = target if predTaken, else fetchPc+4 (mod 2^32; 0xFFFFFFFC -> 0x00000000).
- Update when upd = exValid && exIsBranch:
  - Taken, hit: ctr = sat_inc(ctr), max 2'b11; target = exIrregPc.
  - Taken, miss: allocate/overwrite the entry with valid=1, tag, target=exIrregPc, ctr=2'b10.
  - Not taken, hit: ctr = sat_dec(ctr), min 2'b00; target unchanged.
  - Not taken, miss: no change; no allocation.
  - No update when exValid=0 or exIsBranch=0.
- Simultaneous lookup/update to the same idx: lookup returns the pre-update entry (no bypass). The new value is visible the next cycle.
- Mispredict detection: mis = upd && (exIrregPc != exPredNextPc).
  - Next edge: mispredict <= mis; recoverPc <= exIrregPc if mis, else hold.
  - Exactly a one-cycle pulse per mispredicted branch. Back-to-back mispredicts give consecutive pulses, each carrying its own recoverPc.
  - Latency: execute result at cycle N -> mispredict at cycle N+1.
- Non-branch with exValid=1: no mispredict, no training, no stat change.
- Statistics:
  - branchCount +1 per upd.
  - mispredictCount +1 per mis.
  - Both saturate at all-ones and never wrap.

Test Plan:
- Reset then lookup:
  - Stimulus: assert rst; release; fetchPc=0x00000100.
  - Required: predTaken=0, predNextPc=0x00000104, mispredict=0, counts=0.
- Taken allocate + predict:
  - Stimulus: upd with exPc=0x100, taken, exIrregPc=0x200, exPredNextPc=0x104.
  - Required next cycle: mispredict=1, recoverPc=0x200, mispredictCount=1.
  - Required thereafter: fetchPc=0x100 gives predTaken=1, predNextPc=0x200.
- Counter hysteresis:
  - Stimulus: after allocate (ctr=10), resolve 0x100 not-taken once.
  - Required: predTaken=0 (ctr=01). Two taken resolves -> ctr=11; one not-taken -> still predTaken=1.
- Aliasing (ENTRY_NUM=64):
  - Stimulus: taken at 0x100, then taken at 0x200 with target 0x300; the two share idx 0 with different tags.
  - Required: fetchPc=0x100 -> predNextPc=0x104 (tag miss); fetchPc=0x200 -> predNextPc=0x300.
- Same-cycle read/update and wrap:
  - Stimulus: fetchPc=exPc=0x100 during the allocating update.
  - Required: predNextPc=0x104 that cycle, 0x200 the next. fetchPc=0xFFFFFFFC with a miss -> predNextPc=0x00000000.
- Reset mid-stream and saturation:
  - Stimulus: assert rst in the cycle after a mispredict.
  - Required: mispredict drops asynchronously and the table clears.
  - With STAT_WIDTH=4: 17 mispredicts -> mispredictCount=4'hF.
